// File: rtl/rgb_led_sequencer.sv
// RGB LED sequencer: a small colour table stepped at a fixed rate, with per-channel
// PWM brightness driving the open-drain LED pins.
module rgb_led_sequencer #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 12000000,
    parameter int NSTEPS   = 4,
    parameter int IW       = 2
) (
    input  logic                    clkin,
    input  logic                    resetn,
    input  logic                    run,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [IW-1:0]           cfg_addr,
    input  logic [3*PWM_BITS-1:0]   cfg_rgb,
    output logic [2:0]              led_on,
    output logic [IW-1:0]           step_idx,
    output logic                    step_pulse
);

    localparam int PRESC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX    = {PWM_BITS{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [PRESC_W-1:0]      r_presc;
    logic [IW-1:0]           r_step_idx;
    logic                    r_step_pulse;
    logic                    r_cfg_ready;
    logic [3*PWM_BITS-1:0]   r_pend;
    logic [3*PWM_BITS-1:0]   r_duty;
    logic [3*PWM_BITS-1:0]   r_table [NSTEPS];
    logic [PWM_BITS-1:0]     r_pwm_cnt;
    logic [2:0]              r_led_on;

    logic                    w_wr;
    logic                    w_step_wrap;
    logic [IW-1:0]           w_next_idx;
    logic [3*PWM_BITS-1:0]   w_step_rgb;
    logic [2:0]              w_led_next;

    assign w_wr        = cfg_valid & r_cfg_ready;
    assign w_step_wrap = (r_presc == PRESC_LAST);
    assign w_next_idx  = r_step_idx + IW'(1);
    // A write landing on the entry being stepped into is forwarded straight to pend.
    assign w_step_rgb  = (w_wr && (cfg_addr == w_next_idx)) ? cfg_rgb : r_table[w_next_idx];

    // Colour table storage, cleared by reset.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NSTEPS; i++) begin
                r_table[i] <= {(3*PWM_BITS){1'b0}};
            end
        end else if (w_wr) begin
            r_table[cfg_addr] <= cfg_rgb;
        end
    end

    // Sequencer FSM: step prescaler, index, pending duty and handshake.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_presc      <= {PRESC_W{1'b0}};
            r_step_idx   <= {IW{1'b0}};
            r_step_pulse <= 1'b0;
            r_cfg_ready  <= 1'b0;
            r_pend       <= {(3*PWM_BITS){1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_presc      <= {PRESC_W{1'b0}};
                    r_step_idx   <= {IW{1'b0}};
                    r_step_pulse <= 1'b0;
                    r_pend       <= {(3*PWM_BITS){1'b0}};
                    if (run) begin
                        r_state     <= ST_LOAD;
                        r_cfg_ready <= 1'b0;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_cfg_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_presc      <= {PRESC_W{1'b0}};
                    r_step_idx   <= {IW{1'b0}};
                    r_step_pulse <= 1'b0;
                    r_pend       <= r_table[0];
                    r_cfg_ready  <= 1'b1;
                    r_state      <= run ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    r_cfg_ready <= 1'b1;
                    if (!run) begin
                        r_state      <= ST_IDLE;
                        r_presc      <= {PRESC_W{1'b0}};
                        r_step_idx   <= {IW{1'b0}};
                        r_step_pulse <= 1'b0;
                    end else if (w_step_wrap) begin
                        r_state      <= ST_RUN;
                        r_presc      <= {PRESC_W{1'b0}};
                        r_step_idx   <= w_next_idx;
                        r_step_pulse <= 1'b1;
                        r_pend       <= w_step_rgb;
                    end else begin
                        r_state      <= ST_RUN;
                        r_presc      <= r_presc + PRESC_W'(1);
                        r_step_pulse <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_presc      <= {PRESC_W{1'b0}};
                    r_step_idx   <= {IW{1'b0}};
                    r_step_pulse <= 1'b0;
                    r_cfg_ready  <= 1'b1;
                    r_pend       <= {(3*PWM_BITS){1'b0}};
                end
            endcase
        end
    end

    // LED compare; a dropped run darkens the LEDs on the very next edge.
    always_comb begin
        w_led_next = 3'b000;
        if ((r_state == ST_RUN) && run) begin
            w_led_next[2] = (r_pwm_cnt < r_duty[3*PWM_BITS-1:2*PWM_BITS]);
            w_led_next[1] = (r_pwm_cnt < r_duty[2*PWM_BITS-1:PWM_BITS]);
            w_led_next[0] = (r_pwm_cnt < r_duty[PWM_BITS-1:0]);
        end else begin
            w_led_next = 3'b000;
        end
    end

    // PWM counter and active duty; duty only changes at the counter wrap so periods stay whole.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            r_pwm_cnt <= {PWM_BITS{1'b0}};
            r_duty    <= {(3*PWM_BITS){1'b0}};
            r_led_on  <= 3'b000;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            if (r_state == ST_IDLE) begin
                r_duty <= {(3*PWM_BITS){1'b0}};
            end else if (r_pwm_cnt == PWM_MAX) begin
                r_duty <= r_pend;
            end else begin
                r_duty <= r_duty;
            end
            r_led_on <= w_led_next;
        end
    end

    assign cfg_ready  = r_cfg_ready;
    assign led_on     = r_led_on;
    assign step_idx   = r_step_idx;
    assign step_pulse = r_step_pulse;

endmodule
